mult_seq_16: RTL and testbench

//   Multi-cycle unsigned 16x16 -> 32-bit shift-add multiplier for the EX stage (MULTU path).

---
 rtl/mult_seq_16.sv | 127 ++++++++++++
 tb/tb_mult_seq_16.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_16.sv
// rtl/mult_seq_16.sv - sequential unsigned 16x16 shift-add multiplier with carry-select adder

// csa_16: 16-bit carry-select adder. Low byte ripples; the high byte is
// precomputed for both carry-in values and selected by the low-byte carry.
module csa_16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] s,
   output logic        c
);
   logic [8:0] lo_sum;
   logic [8:0] hi_sum0;
   logic [8:0] hi_sum1;

   // Both high-byte candidates and the low byte are evaluated in parallel
   always_comb begin
      lo_sum  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'h00, cin};
      hi_sum0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
      hi_sum1 = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;
      s[7:0]  = lo_sum[7:0];
      if (lo_sum[8]) begin
         s[15:8] = hi_sum1[7:0];
         c       = hi_sum1[8];
      end else begin
         s[15:8] = hi_sum0[7:0];
         c       = hi_sum0[8];
      end
   end
endmodule

// mult_seq_16: one add-and-shift step per RUN cycle, 16 steps, then FIN
// publishes the accumulator to product and pulses done.
module mult_seq_16 #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t             state;
   state_t             state_n;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mcand;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   sum;
   logic               carry;

   // The single adder always adds the multiplicand into the upper accumulator half
   csa_16 u_csa (
      .a   (acc[2*WIDTH-1:WIDTH]),
      .b   (mcand),
      .cin (1'b0),
      .s   (sum),
      .c   (carry)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state decode: fixed 16 RUN cycles, no early exit
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (cnt == LAST) state_n = FIN;
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Datapath: capture operands, add/shift in RUN, publish result in FIN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         mcand   <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand <= a;
                  acc   <= {{WIDTH{1'b0}}, b};
                  cnt   <= '0;
               end
            end
            RUN: begin
               // Adder carry becomes the 33rd bit and shifts into acc MSB
               if (acc[0]) acc <= {carry, sum, acc[WIDTH-1:1]};
               else        acc <= {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
            end
            FIN:     product <= acc;
            default: ;
         endcase
      end
   end

   // Registered status: busy mirrors RUN, done pulses for one cycle after FIN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_n == RUN);
         done <= (state == FIN);
      end
   end
endmodule

// File: tb/tb_mult_seq_16.sv
// tb/tb_mult_seq_16.sv - self-checking bench for mult_seq_16
module tb_mult_seq_16;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [31:0] product;

   int vectors     = 0;
   int miscompares = 0;

   mult_seq_16 dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] p;
   } vec_t;

   vec_t tbl[9];

   function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
      return {16'h0, x} * {16'h0, y};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Present start for one cycle; returns at the first negedge after the accepting edge (cycle 1)
   task automatic launch(input logic [15:0] x, input logic [15:0] y);
      start = 1'b1;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
      a     = 16'($urandom);
      b     = 16'($urandom);
   endtask

   // Walk cycles until done is seen (bounded); returns at the done cycle
   task automatic wait_done(input int from_cyc, input logic [31:0] hold,
                            output int lat, output int busy_n, output int chg);
      int cyc;
      cyc    = from_cyc;
      lat    = 0;
      busy_n = 0;
      chg    = 0;
      while (cyc <= 40 && lat == 0) begin
         if (busy === 1'b1) busy_n++;
         if (done === 1'b1) lat = cyc;
         else begin
            if (product !== hold) chg++;
            @(negedge clk);
            cyc++;
         end
      end
      if (lat == 0) lat = cyc;
   endtask

   initial begin
      int          lat;
      int          bn;
      int          chg;
      int          dn;
      logic [31:0] prev;
      logic [31:0] exp;
      logic [15:0] x;
      logic [15:0] y;

      tbl[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
      tbl[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
      tbl[2] = '{16'h1234, 16'h0000, 32'h0000_0000};
      tbl[3] = '{16'h0000, 16'hABCD, 32'h0000_0000};
      tbl[4] = '{16'h8000, 16'h0002, 32'h0001_0000};
      tbl[5] = '{16'h1234, 16'h5678, 32'h0626_0060};
      tbl[6] = '{16'h00FF, 16'h0100, 32'h0000_FF00};
      tbl[7] = '{16'h8000, 16'h8000, 32'h4000_0000};
      tbl[8] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_product", product, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table-driven directed vectors, full latency/pulse checks on each
      for (int i = 0; i < 9; i++) begin
         prev = product;
         launch(tbl[i].a, tbl[i].b);
         wait_done(1, prev, lat, bn, chg);
         check($sformatf("tbl%0d_product", i), product, tbl[i].p);
         check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd18);
         check($sformatf("tbl%0d_busy_cycles", i), 32'(bn), 32'd16);
         check($sformatf("tbl%0d_product_stable_in_run", i), 32'(chg), 32'd0);
         @(negedge clk);
         check($sformatf("tbl%0d_done_pulse_width", i), {31'b0, done}, 32'd0);
         check($sformatf("tbl%0d_product_hold", i), product, tbl[i].p);
      end

      // Start pulsed mid-run is ignored
      prev = product;
      exp  = ref_mul(16'h00C8, 16'h0101);
      launch(16'h00C8, 16'h0101);
      repeat (4) @(negedge clk);
      start = 1'b1;
      a     = 16'h0007;
      b     = 16'h0007;
      @(negedge clk);
      start = 1'b0;
      wait_done(6, prev, lat, bn, chg);
      check("midrun_start_product", product, exp);
      check("midrun_start_latency", 32'(lat), 32'd18);
      @(negedge clk);
      check("midrun_start_no_restart", {31'b0, busy}, 32'd0);

      // Reset in RUN cycle 8 aborts without done
      launch(16'h1111, 16'h2222);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      check("abort_product", product, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dn  = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done === 1'b1) dn++;
      end
      check("abort_no_done", 32'(dn), 32'd0);
      launch(16'h0005, 16'h0006);
      wait_done(1, 32'd0, lat, bn, chg);
      check("after_abort_product", product, 32'd30);
      check("after_abort_latency", 32'(lat), 32'd18);

      // Simultaneous start and rst: reset wins
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("start_with_rst_busy", {31'b0, busy}, 32'd0);
      check("start_with_rst_product", product, 32'd0);

      // Back-to-back: start in the done cycle
      launch(16'h0009, 16'h000B);
      wait_done(1, 32'd0, lat, bn, chg);
      check("b2b_first_product", product, 32'd99);
      prev = product;
      launch(16'h8000, 16'h0002);
      wait_done(1, prev, lat, bn, chg);
      check("b2b_second_product", product, 32'h0001_0000);
      check("b2b_second_latency", 32'(lat), 32'd18);
      check("b2b_second_busy_cycles", 32'(bn), 32'd16);

      // Randomized pairs against plain multiplication
      for (int n = 0; n < 1000; n++) begin
         x = 16'($urandom);
         y = 16'($urandom);
         case ($urandom_range(0, 15))
            0:       x = 16'h0000;
            1:       y = 16'h0000;
            2:       x = 16'hFFFF;
            3:       y = 16'hFFFF;
            default: ;
         endcase
         exp  = ref_mul(x, y);
         prev = product;
         launch(x, y);
         wait_done(1, prev, lat, bn, chg);
         check($sformatf("rand%0d_%04h_x_%04h", n, x, y), product, exp);
         if (lat != 18) check($sformatf("rand%0d_latency", n), 32'(lat), 32'd18);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
